// File: rtl/mst_fifo_prefetch.sv
// Per-channel prefetch buffers feeding the master FIFO bus state machine from the internal FIFO bank.
// Optional PREF_FLUSH_EN adds pref_flush to drop all buffered and in-flight words.

module mst_fifo_prefetch_chan #(
  parameter int DEPTH = 4,
  parameter int DW    = 36
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [$clog2(DEPTH):0]     cnt,
  output logic [DW-1:0]              head,
  output logic                       nempt
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] ram [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, wr_nxt, rd_nxt;

  always_comb begin
    wr_nxt = wr_ptr + (AW+1)'(push);
    rd_nxt = rd_ptr + (AW+1)'(pop);
    if (flush) begin
      wr_nxt = wr_ptr;
      rd_nxt = wr_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      nempt  <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      nempt  <= (wr_nxt != rd_nxt);
    end
  end

  // Storage is not reset; the output mux masks it while the buffer is empty.
  always_ff @(posedge clk) begin
    if (push && !flush)
      ram[wr_ptr[AW-1:0]] <= push_data;
  end

  assign cnt  = wr_ptr - rd_ptr;
  assign head = ram[rd_ptr[AW-1:0]];
endmodule

module mst_fifo_prefetch #(
  parameter int DEPTH = 4,
  parameter int DW    = 36
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prefena,
  input  logic          prefreq,
  input  logic [1:0]    prefchn,
  output logic [3:0]    prefnempt,
  output logic [DW-1:0] prefdout,
  input  logic [3:0]    ofifo_nempt,
  output logic          ofifo_rd,
  output logic [1:0]    ofifo_rdid,
  input  logic [DW-1:0] ofifo_rdat,
`ifdef PREF_FLUSH_EN
  input  logic          pref_flush,
`endif
  output logic          pref_udf
);
  localparam int NCH = 4;
  localparam int CW  = $clog2(DEPTH) + 1;

  typedef enum logic {FIDLE, FWAIT} fstate_t;
  typedef struct packed {
    logic       vld;
    logic       rr;
    logic [1:0] ch;
  } fetch_req_t;

  fstate_t                   state, state_nxt;
  fetch_req_t                gnt;
  logic                      flush, issue;
  logic [1:0]                wid, rr_ptr, rr_idx;
  logic [NCH-1:0][CW-1:0]    cnt;
  logic [NCH-1:0][DW-1:0]    head;
  logic [NCH-1:0]            nempt, pend, room, elig, push, pop;

`ifdef PREF_FLUSH_EN
  assign flush = pref_flush;
`else
  assign flush = 1'b0;
`endif

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    // The word in flight already owns a slot, so it counts against room.
    assign pend[g] = (state == FWAIT) && (wid == 2'(g));
    assign room[g] = ({1'b0, cnt[g]} + {{CW{1'b0}}, pend[g]}) < (CW+1)'(DEPTH);
    assign elig[g] = ofifo_nempt[g] && room[g];
    assign push[g] = pend[g];
    assign pop[g]  = prefreq && (prefchn == 2'(g)) && (cnt[g] != '0) && !flush;

    mst_fifo_prefetch_chan #(.DEPTH(DEPTH), .DW(DW)) u_chan (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (push[g]),
      .push_data (ofifo_rdat),
      .pop       (pop[g]),
      .cnt       (cnt[g]),
      .head      (head[g]),
      .nempt     (nempt[g])
    );
  end

  // Write-state channel wins outright; otherwise round-robin from rr_ptr.
  always_comb begin
    gnt    = '0;
    rr_idx = '0;
    if (prefena && elig[prefchn]) begin
      gnt = '{vld: 1'b1, rr: 1'b0, ch: prefchn};
    end else begin
      for (int i = 0; i < NCH; i++) begin
        rr_idx = rr_ptr + 2'(i);
        if (!gnt.vld && elig[rr_idx])
          gnt = '{vld: 1'b1, rr: 1'b1, ch: rr_idx};
      end
    end
  end

  assign issue = gnt.vld && !rst && !flush;

  always_comb begin
    state_nxt  = state;
    ofifo_rd   = 1'b0;
    ofifo_rdid = '0;
    if (issue) begin
      ofifo_rd   = 1'b1;
      ofifo_rdid = gnt.ch;
    end
    unique case (state)
      FIDLE:   state_nxt = issue ? FWAIT : FIDLE;
      FWAIT:   state_nxt = issue ? FWAIT : FIDLE;
      default: state_nxt = FIDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FIDLE;
      wid      <= '0;
      rr_ptr   <= '0;
      pref_udf <= 1'b0;
    end else begin
      state <= state_nxt;
      if (issue)
        wid <= gnt.ch;
      if (issue && gnt.rr)
        rr_ptr <= gnt.ch + 2'd1;
      if (prefreq && (cnt[prefchn] == '0))
        pref_udf <= 1'b1;
    end
  end

  assign prefnempt = nempt;
  assign prefdout  = (cnt[prefchn] != '0) ? head[prefchn] : '0;
endmodule

// File: doc/mst_fifo_prefetch.md
Name: mst_fifo_prefetch

Overview:
- Per-channel prefetch buffer between the four internal FIFO read ports and the master FIFO bus state machine.
- Keeps up to DEPTH words per channel pre-read from the internal FIFOs.
- The state machine pops a word on prefreq and drives it on the bus in the next cycle.
- Hides the 1-cycle read latency of the internal FIFO RAM during write bursts to the FT600.

Parameters:
- DEPTH, 4, entries per channel buffer; power of two, at least 2.
- DW, 36, word width, {be[3:0], data[31:0]}.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- prefena  in  1  high while the state machine is in its write state.
- prefreq  in  1  pop request for channel prefchn.
- prefchn  in  2  selected channel.
- prefnempt  out  4  bit n high when channel n buffer holds at least 1 word.
- prefdout  out  DW  head word of the prefchn buffer.
- ofifo_nempt  in  4  internal FIFO n not empty.
- ofifo_rd  out  1  read strobe to the internal FIFO bank.
- ofifo_rdid  out  2  channel being read; valid with ofifo_rd.
- ofifo_rdat  in  DW  read data, valid exactly 1 cycle after ofifo_rd.
- pref_udf  out  1  sticky underflow flag.
- pref_flush  in  1  present only with PREF_FLUSH_EN.

Behaviour:
- Single clock domain. All state is reset synchronously when rst=1 on a clk edge.
- Reset values: all buffers empty, prefnempt=0, prefdout=0, ofifo_rd=0, ofifo_rdid=0, pref_udf=0. Round-robin pointer=0. Fetch FSM in FIDLE.
- Buffer per channel: circular RAM of DEPTH entries with wr_ptr/rd_ptr of log2(DEPTH)+1 bits; the MSB distinguishes full from empty.
  - cnt[n] = wr_ptr - rd_ptr (modulo arithmetic, wraps naturally).
  - pend[n] = 1 while a read for channel n is in flight.
- Output mux:
  - prefdout = buffer[prefchn][rd_ptr] combinationally, so the state machine registers it on the same edge it pops.
  - prefdout = 0 when that buffer is empty.
- Pop: on a clock edge with prefreq=1 and cnt[prefchn]!=0, rd_ptr[prefchn] advances by 1.
- Underflow: prefreq=1 with cnt[prefchn]=0 does not move pointers and sets pref_udf. pref_udf is cleared only by rst.
- Room: channel n has room when cnt[n] + pend[n] < DEPTH. Never overfill; the in-flight word counts against room.
- Fetch arbitration, one read per cycle at most:
  - When prefena=1: channel prefchn has absolute priority if ofifo_nempt[prefchn] and it has room.
  - Otherwise, round-robin over channels with ofifo_nempt[n] and room, starting at rr_ptr. rr_ptr moves to the granted channel + 1, mod 4.
- Fetch FSM:
  - FIDLE: a grant exists -> assert ofifo_rd, set ofifo_rdid, go to FWAIT.
  - FWAIT: ofifo_rdat is written into buffer[rdid] at wr_ptr, and wr_ptr increments. If a further grant exists, a new ofifo_rd is issued in the same cycle (back-to-back, 1 word/cycle sustained) and the FSM stays in FWAIT; otherwise go to FIDLE.
- A read is never issued on a channel with ofifo_nempt=0. ofifo_nempt is trusted to reflect the read issued in the previous cycle.
- Simultaneous pop and write on the same channel are both performed; cnt is unchanged.
- Same-cycle push into an empty buffer: prefnempt rises the next cycle. There is no bypass of ofifo_rdat to prefdout.
- prefnempt is registered from the next-state cnt != 0.
- A pop on the last word clears prefnempt in the following cycle.
- prefchn changing mid-burst only changes the mux select; no state is lost.
- Reset during an in-flight read: the word arriving next cycle is dropped. The buffers are empty after reset.

Optional Feature:
- Macro PREF_FLUSH_EN.
- Defined: adds input port pref_flush. pref_flush=1 on a clock edge empties all four buffers (rd_ptr=wr_ptr) and discards any in-flight word (pend cleared, the next ofifo_rdat is ignored). prefnempt=0 next cycle. pref_udf is kept. No read is issued in the flush cycle. This lets the state machine discard stale data after a checker error.
- Not defined: no pref_flush port; buffers are cleared only by rst.

Test Plan:
- Reset, then ch0 ofifo_nempt=1 with data 0x1_00000001.. -> reads issued back-to-back on rdid=0. ofifo_rd drops once 4 words are held or in flight. prefnempt=4'b0001 and prefdout=0x100000001.
- prefena=1, prefchn=0, prefreq held 8 cycles with the source continuously non-empty -> prefdout sequence 1..8 with no gaps and no duplicates. cnt never exceeds 4.
- prefena=0, all four internal FIFOs non-empty -> rdid sequence 0,1,2,3,0,... until each buffer holds 4 words. prefnempt=4'hF.
- prefena=1 and prefchn=2 while ch0, ch1 and ch3 also request -> ch2 is granted every cycle until full or empty.
- prefreq=1 on an empty channel 1 -> pointers unchanged, pref_udf=1 sticky until rst.
- With PREF_FLUSH_EN: pulse pref_flush with a read in flight -> prefnempt=0 the next cycle, and the in-flight word is absent from prefdout after a refill.
